shift_unit_pipe: RTL and testbench
==================================

Name: shift_unit_pipe

Overview:
- Pipelined, parametrised barrel shifter for the NPC execute stage. It replaces the single-cycle combinational shifter on the ALU shift path.
- Covers RV64I shifts, including the 32-bit W variants, plus Zbb rotates.
- Splits the log2(XLEN) shift levels across STAGES register stages.
- Uses a valid/ready handshake with backpressure, synchronous flush and a pass-through tag, so it can run multi-cycle beside the ALU.

Parameters:
XLEN, 64, datapath width; legal values are 32 and 64.
STAGES, 2, pipeline register stages (1..log2(XLEN)); latency in cycles.
TAG_W, 5, width of the tag carried alongside each operation (e.g. rd index).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all in-flight operations
in_valid  in  1  operation presented
in_ready  out  1  unit can accept this cycle
in_op  in  4  operation code (see package)
in_src1  in  XLEN  value to shift
in_src2  in  XLEN  shift amount source; only the low bits are used
in_tag  in  TAG_W  opaque tag
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_result  out  XLEN  shifted result
out_tag  out  TAG_W  tag of the result
out_illegal  out  1  op was not legal for this XLEN; out_result is 0

Behaviour:
- Reset (rst_n low, asynchronous): all stage valids = 0, so out_valid = 0. out_result, out_tag and out_illegal = 0. in_ready = 1 once reset is released.
- Opcodes:
  - 0 SRAW, 1 SRLW, 2 SLLW
  - 3 SRL, 4 SLL, 5 SRA
  - 6 ROR, 7 ROL, 8 RORW, 9 ROLW
  - 10..15 illegal
- Shift amount:
  - Full-width ops use src2[log2(XLEN)-1:0].
  - W ops use src2[4:0].
  - Upper src2 bits are ignored.
- W ops:
  - Operate on src1[31:0] only.
  - The 32-bit result is sign-extended from bit 31 to XLEN. This applies to SRLW, SLLW and the rotates too, per RV64.
- XLEN=32: W ops (0,1,2,8,9) are illegal.
- Illegal ops:
  - Still travel the pipeline and consume a slot.
  - Retire with out_illegal=1, out_result=0 and the tag preserved.
- Arithmetic right shifts fill with the sign of the operand width (bit 31 for W, bit XLEN-1 otherwise). Logical shifts fill with 0. Rotates wrap bits around.
- A shift amount of 0 returns src1 unchanged for full ops, and sign-extended src1[31:0] for W ops.
- Pipeline:
  - Stage k performs levels [k*L, (k+1)*L), where L = ceil(log2(XLEN)/STAGES). The final stage may hold fewer levels.
  - Each stage register holds: valid, partial value, op, remaining amount, tag.
  - Latency is exactly STAGES cycles from an in_valid&&in_ready edge to out_valid, when out_ready stays high.
- Handshake:
  - The last stage advances when ~valid_last | out_ready.
  - Stage k advances when ~valid_{k+1} | advance_{k+1}.
  - in_ready = advance_0.
  - Full throughput is 1 op/cycle with no bubbles while out_ready=1.
  - out_result, out_tag and out_illegal hold stable while out_valid && !out_ready.
  - in_ready is combinational from out_ready; there is no combinational path from in_valid to out_*.
- Full pipeline with out_ready=0: in_ready=0, and the held input is not captured.
- Simultaneous out_ready and in_valid on a full pipe: the whole pipe shifts in the same cycle, so the new op is accepted.
- flush:
  - Clears all valids on the next edge and has priority over acceptance. An op presented in the flush cycle is dropped.
  - out_valid=0 the cycle after flush.
  - Data registers need not clear.
- Reset mid-operation: all in-flight ops are discarded immediately (asynchronous); nothing is output after release.

Decomposition:
- Package shift_pkg holds:
  - the shift_op_e enum (codes 0..15) and the helper is_word_op / is_right / is_arith / is_rotate decode function
  - the XLEN-dependent constant SHAMT_W = $clog2(XLEN)
- One sub-module, shift_stage: combinational levels [LO,HI) of the shifter plus the stage register and its valid/advance logic. It is instantiated STAGES times via generate.
- Pre-stage normalisation (W extension, left-shift bit reversal) and post-stage result formatting (sign-extension, illegal zeroing) live in the top level.

Test Plan:
- SRA, src1=64'h8000_0000_0000_0000, src2=4 -> out_result=64'hF800_0000_0000_0000 exactly STAGES cycles after acceptance; tag 5'd7 is echoed.
- SRLW, src1=64'hFFFF_FFFF_8000_0000, src2=64'h21 (amount 1) -> out_result=64'h0000_0000_4000_0000. SLLW, src1=1, src2=31 -> 64'hFFFF_FFFF_8000_0000.
- ROL, src1=64'h8000_0000_0000_0001, src2=1 -> 64'h0000_0000_0000_0003. RORW, src1=64'h1, src2=1 -> 64'hFFFF_FFFF_8000_0000.
- Back-to-back stream of 10 ops with out_ready low for 3 cycles mid-stream:
  - in_ready deasserts once the pipe is full
  - outputs stay stable while stalled
  - all 10 results return in order with correct tags; no drops or duplicates
- flush asserted with 2 ops in flight and in_valid=1 -> out_valid=0 the next cycle; none of the 3 ops ever appear; the next accepted op returns normally.
- in_op=12 -> out_illegal=1, out_result=0. With XLEN=32, SRAW -> out_illegal=1. rst_n pulsed low mid-stream -> out_valid drops asynchronously and stays 0 until new input is accepted.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared opcode encoding and decode helpers for the pipelined shift unit.
`timescale 1ns/1ps
package shift_pkg;

  typedef enum logic [3:0] {
    OP_SRAW  = 4'd0,
    OP_SRLW  = 4'd1,
    OP_SLLW  = 4'd2,
    OP_SRL   = 4'd3,
    OP_SLL   = 4'd4,
    OP_SRA   = 4'd5,
    OP_ROR   = 4'd6,
    OP_ROL   = 4'd7,
    OP_RORW  = 4'd8,
    OP_ROLW  = 4'd9,
    OP_ILL10 = 4'd10,
    OP_ILL11 = 4'd11,
    OP_ILL12 = 4'd12,
    OP_ILL13 = 4'd13,
    OP_ILL14 = 4'd14,
    OP_ILL15 = 4'd15
  } shift_op_e;

  localparam int XLEN_DEFAULT = 64;
  localparam int SHAMT_W      = $clog2(XLEN_DEFAULT);

  // Shift-amount width for any legal XLEN (SHAMT_W is the default-width value).
  function automatic int shamt_w_of(input int xlen);
    return $clog2(xlen);
  endfunction

  function automatic logic is_word_op(input logic [3:0] op);
    return op inside {OP_SRAW, OP_SRLW, OP_SLLW, OP_RORW, OP_ROLW};
  endfunction

  function automatic logic is_right(input logic [3:0] op);
    return op inside {OP_SRAW, OP_SRLW, OP_SRL, OP_SRA, OP_ROR, OP_RORW};
  endfunction

  function automatic logic is_arith(input logic [3:0] op);
    return op inside {OP_SRAW, OP_SRA};
  endfunction

  function automatic logic is_rotate(input logic [3:0] op);
    return op inside {OP_ROR, OP_ROL, OP_RORW, OP_ROLW};
  endfunction

  function automatic logic is_illegal(input logic [3:0] op, input logic xlen32);
    return (op > OP_ROLW) || (xlen32 && is_word_op(op));
  endfunction

endpackage

// File: rtl/shift_unit_pipe_stage.sv
// One pipeline slice: right-shift/rotate levels [LO,HI) followed by the stage register.
`timescale 1ns/1ps
module shift_stage
  import shift_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int AMT_W = 6,
  parameter int TAG_W = 5,
  parameter int LO    = 0,
  parameter int HI    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             prev_valid,
  input  logic [XLEN-1:0]  prev_value,
  input  logic [3:0]       prev_op,
  input  logic [AMT_W-1:0] prev_amt,
  input  logic [TAG_W-1:0] prev_tag,
  input  logic             next_adv,
  output logic             adv,
  output logic             valid,
  output logic [XLEN-1:0]  value,
  output logic [3:0]       op,
  output logic [AMT_W-1:0] amt,
  output logic [TAG_W-1:0] tag
);

  logic [XLEN-1:0] shifted;
  logic            fill;
  logic            rot;

  // An arithmetic right shift keeps the MSB, so the sign fill is stable across stages.
  assign fill = is_arith(prev_op) & prev_value[XLEN-1];
  assign rot  = is_rotate(prev_op);

  always_comb begin
    shifted = prev_value;
    for (int i = LO; i < HI; i++) begin
      if (prev_amt[i]) begin
        if (rot) shifted = (shifted >> (1 << i)) | (shifted << (XLEN - (1 << i)));
        else     shifted = (shifted >> (1 << i)) | (fill ? ~({XLEN{1'b1}} >> (1 << i)) : '0);
      end
    end
  end

  assign adv = ~valid | next_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      value <= '0;
      op    <= '0;
      amt   <= '0;
      tag   <= '0;
    end else begin
      if (flush)    valid <= 1'b0;
      else if (adv) valid <= prev_valid;
      if (adv && prev_valid) begin
        value <= shifted;
        op    <= prev_op;
        amt   <= prev_amt;
        tag   <= prev_tag;
      end
    end
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined RV64I/Zbb shifter: every op is normalised to a right shift/rotate, run
// through STAGES register slices, then reversed/sign-extended/zeroed on the way out.
// Handshake: a transfer happens on a rising edge where valid && ready; ready never
// depends on valid, and flush drops everything in flight including the presented op.
`timescale 1ns/1ps
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int  AMT_W  = shamt_w_of(XLEN);
  localparam int  L      = (AMT_W + STAGES - 1) / STAGES;
  localparam logic XLEN32 = (XLEN == 32);

  logic             valid_c [STAGES+1];
  logic             adv_c   [STAGES+1];
  logic [XLEN-1:0]  value_c [STAGES+1];
  logic [3:0]       op_c    [STAGES+1];
  logic [AMT_W-1:0] amt_c   [STAGES+1];
  logic [TAG_W-1:0] tag_c   [STAGES+1];

  logic [XLEN-1:0]  norm;
  logic [XLEN-1:0]  res;
  logic             unused_bits;

  // W rotates see two copies of the low word so wrapped bits land in the low half.
  always_comb begin
    norm = in_src1;
    if (is_word_op(in_op)) begin
      if (is_rotate(in_op))     norm = {(XLEN/32){in_src1[31:0]}};
      else if (is_arith(in_op)) norm = XLEN'($signed(in_src1[31:0]));
      else                      norm = XLEN'(in_src1[31:0]);
    end
    if (!is_right(in_op)) begin
      for (int i = 0; i < XLEN; i++) value_c[0][i] = norm[XLEN-1-i];
    end else begin
      value_c[0] = norm;
    end
  end

  assign valid_c[0]      = in_valid;
  assign op_c[0]         = in_op;
  assign amt_c[0]        = is_word_op(in_op) ? AMT_W'(in_src2[4:0]) : in_src2[AMT_W-1:0];
  assign tag_c[0]        = in_tag;
  assign adv_c[STAGES]   = out_ready;
  assign in_ready        = adv_c[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = (k * L < AMT_W) ? k * L : AMT_W;
    localparam int HI = ((k + 1) * L < AMT_W) ? (k + 1) * L : AMT_W;
    shift_stage #(
      .XLEN (XLEN),
      .AMT_W(AMT_W),
      .TAG_W(TAG_W),
      .LO   (LO),
      .HI   (HI)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .prev_valid(valid_c[k]),
      .prev_value(value_c[k]),
      .prev_op   (op_c[k]),
      .prev_amt  (amt_c[k]),
      .prev_tag  (tag_c[k]),
      .next_adv  (adv_c[k+1]),
      .adv       (adv_c[k]),
      .valid     (valid_c[k+1]),
      .value     (value_c[k+1]),
      .op        (op_c[k+1]),
      .amt       (amt_c[k+1]),
      .tag       (tag_c[k+1])
    );
  end

  always_comb begin
    res = value_c[STAGES];
    if (!is_right(op_c[STAGES])) begin
      for (int i = 0; i < XLEN; i++) res[i] = value_c[STAGES][XLEN-1-i];
    end
    if (is_word_op(op_c[STAGES])) res = XLEN'($signed(res[31:0]));
    out_result  = '0;
    out_illegal = 1'b0;
    if (valid_c[STAGES]) begin
      out_illegal = is_illegal(op_c[STAGES], XLEN32);
      out_result  = out_illegal ? '0 : res;
    end
  end

  assign out_valid   = valid_c[STAGES];
  assign out_tag     = valid_c[STAGES] ? tag_c[STAGES] : '0;
  assign unused_bits = ^{in_src2[XLEN-1:AMT_W], amt_c[STAGES]};

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Scoreboard bench for shift_unit_pipe: directed spec vectors, random traffic with
// backpressure, stall stability, flush, mid-stream reset and an XLEN=32 instance.
`timescale 1ns/1ps
module tb_shift_unit_pipe;

  localparam int XLEN   = 64;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;
  localparam int EW     = 1 + TAG_W + XLEN;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [63:0]      in_src1;
  logic [63:0]      in_src2;
  logic [4:0]       in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_result;
  logic [4:0]       out_tag;
  logic             out_illegal;

  logic             in_valid32;
  logic             in_ready32;
  logic [3:0]       in_op32;
  logic [31:0]      in_src1_32;
  logic [31:0]      in_src2_32;
  logic [4:0]       in_tag32;
  logic             out_valid32;
  logic             out_ready32;
  logic [31:0]      out_result32;
  logic [4:0]       out_tag32;
  logic             out_illegal32;

  logic [EW-1:0] exp_q[$];
  int  checks;
  int  errors;
  int  acc_cnt;
  int  rx_cnt;
  bit  done;

  shift_unit_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  shift_unit_pipe #(.XLEN(32), .STAGES(2), .TAG_W(TAG_W)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_op(in_op32),
    .in_src1(in_src1_32), .in_src2(in_src2_32), .in_tag(in_tag32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_result(out_result32),
    .out_tag(out_tag32), .out_illegal(out_illegal32)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input logic [4:0] tag);
    logic [31:0] w;
    logic [63:0] r;
    logic        word;
    int          s5;
    int          s6;
    s5 = int'(b[4:0]);
    s6 = int'(b[5:0]);
    w = '0;
    r = '0;
    word = 1'b0;
    case (op)
      4'd0: begin word = 1'b1; w = $signed(a[31:0]) >>> s5; end
      4'd1: begin word = 1'b1; w = a[31:0] >> s5; end
      4'd2: begin word = 1'b1; w = a[31:0] << s5; end
      4'd3: r = a >> s6;
      4'd4: r = a << s6;
      4'd5: r = $signed(a) >>> s6;
      4'd6: r = (a >> s6) | (a << (64 - s6));
      4'd7: r = (a << s6) | (a >> (64 - s6));
      4'd8: begin word = 1'b1; w = (a[31:0] >> s5) | (a[31:0] << (32 - s5)); end
      4'd9: begin word = 1'b1; w = (a[31:0] << s5) | (a[31:0] >> (32 - s5)); end
      default: return {1'b1, tag, 64'd0};
    endcase
    if (word) r = {{32{w[31]}}, w};
    return {1'b0, tag, r};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [EW-1:0] e;
      checks++;
      rx_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got tag=%0d result=%h illegal=%0b, required no output",
                 out_tag, out_result, out_illegal);
      end else begin
        e = exp_q.pop_front();
        if ({out_illegal, out_tag, out_result} !== e) begin
          errors++;
          $display("FAIL result: got illegal=%0b tag=%0d result=%h, required illegal=%0b tag=%0d result=%h",
                   out_illegal, out_tag, out_result, e[EW-1], e[EW-2 -: TAG_W], e[XLEN-1:0]);
        end
      end
    end
    if (flush) exp_q.delete();
  end

  always @(negedge rst_n) exp_q.delete();

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] tag, input logic [EW-1:0] exp);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    in_tag   = tag;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_accept: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end else if (!flush) begin
      exp_q.push_back(exp);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output logic [37:0] obs);
    int n;
    n = 0;
    in_valid32 = 1'b1;
    in_op32    = op;
    in_src1_32 = a;
    in_src2_32 = b;
    in_tag32   = tag;
    @(posedge clk);
    #1;
    in_valid32 = 1'b0;
    @(negedge clk);
    while (!out_valid32 && n < 20) begin
      n++;
      @(negedge clk);
    end
    obs = out_valid32 ? {out_illegal32, out_tag32, out_result32} : '1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_op = '0;
    in_src1 = '0;
    in_src2 = '0;
    in_tag = '0;
    out_ready = 1'b1;
    in_valid32 = 1'b0;
    in_op32 = '0;
    in_src1_32 = '0;
    in_src2_32 = '0;
    in_tag32 = '0;
    out_ready32 = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_illegal, out_tag, out_result} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b illegal=%0b tag=%0d result=%h, required all 0",
               out_valid, out_illegal, out_tag, out_result);
    end
    checks++;
    if ({out_valid32, out_illegal32, out_tag32, out_result32} !== '0) begin
      errors++;
      $display("FAIL reset_outputs32: got valid=%0b illegal=%0b, required all 0",
               out_valid32, out_illegal32);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sra_latency();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_op = 4'd5;
    in_src1 = 64'h8000_0000_0000_0000;
    in_src2 = 64'd4;
    in_tag = 5'd7;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_accept: got in_ready=%0b out_valid=%0b, required 1/0", in_ready, out_valid);
    end
    exp_q.push_back({1'b0, 5'd7, 64'hF800_0000_0000_0000});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 1; c <= STAGES; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (c == STAGES)) begin
        errors++;
        $display("FAIL latency_valid: cycle %0d got out_valid=%0b, required %0b", c, out_valid, c == STAGES);
      end
    end
    checks++;
    if (out_result !== 64'hF800_0000_0000_0000 || out_tag !== 5'd7) begin
      errors++;
      $display("FAIL sra_result: got result=%h tag=%0d, required f800000000000000 tag=7", out_result, out_tag);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_directed();
    out_ready = 1'b1;
    send(4'd1, 64'hFFFF_FFFF_8000_0000, 64'h21, 5'd1, {1'b0, 5'd1, 64'h0000_0000_4000_0000});
    send(4'd2, 64'h1, 64'd31, 5'd2, {1'b0, 5'd2, 64'hFFFF_FFFF_8000_0000});
    send(4'd7, 64'h8000_0000_0000_0001, 64'd1, 5'd3, {1'b0, 5'd3, 64'h3});
    send(4'd8, 64'h1, 64'd1, 5'd4, {1'b0, 5'd4, 64'hFFFF_FFFF_8000_0000});
    send(4'd12, 64'h1234_5678_9ABC_DEF0, 64'd3, 5'd5, {1'b1, 5'd5, 64'd0});
    send(4'd3, 64'hDEAD_BEEF_0123_4567, 64'h40, 5'd6, {1'b0, 5'd6, 64'hDEAD_BEEF_0123_4567});
    send(4'd0, 64'h1234_5678_8765_4321, 64'h20, 5'd8, {1'b0, 5'd8, 64'hFFFF_FFFF_8765_4321});
    send(4'd5, 64'h8000_0000_0000_0000, 64'd63, 5'd9, {1'b0, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF});
    send(4'd6, 64'h0000_0000_0000_00F1, 64'd4, 5'd10, {1'b0, 5'd10, 64'h1000_0000_0000_000F});
    drain();
  endtask

  task automatic test_random();
    done = 1'b0;
    fork
      begin
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  tag;
        for (int i = 0; i < 24; i++) begin
          op  = 4'($urandom_range(0, 15));
          a   = {$urandom, $urandom};
          b   = {$urandom, $urandom};
          tag = 5'($urandom_range(0, 31));
          send(op, a, b, tag, model(op, a, b, tag));
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        int n;
        n = 0;
        while (!done && n < 2000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
          n++;
        end
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_back_to_back();
    int base;
    int rx0;
    base = acc_cnt;
    rx0 = rx_cnt;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [63:0] a;
          logic [3:0]  op;
          a  = {$urandom, $urandom};
          op = 4'(i % 10);
          send(op, a, 64'(i + 3), 5'(10 + i), model(op, a, 64'(i + 3), 5'(10 + i)));
        end
        in_valid = 1'b0;
      end
      begin
        int n;
        logic [63:0] r0;
        logic [4:0]  t0;
        logic        il0;
        n = 0;
        while (acc_cnt < base + 4 && n < 200) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        r0 = out_result;
        t0 = out_tag;
        il0 = out_illegal;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_full: got in_ready=%0b out_valid=%0b, required 0/1", in_ready, out_valid);
        end
        repeat (2) begin
          @(negedge clk);
          checks++;
          if (out_result !== r0 || out_tag !== t0 || out_illegal !== il0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_stable: got result=%h tag=%0d in_ready=%0b, required result=%h tag=%0d in_ready=0",
                     out_result, out_tag, in_ready, r0, t0);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    checks++;
    if (rx_cnt - rx0 != 10) begin
      errors++;
      $display("FAIL stream_count: got %0d results, required 10", rx_cnt - rx0);
    end
  endtask

  task automatic test_flush();
    int rx0;
    out_ready = 1'b0;
    send(4'd3, 64'hAAAA_0000_0000_5555, 64'd1, 5'd20, model(4'd3, 64'hAAAA_0000_0000_5555, 64'd1, 5'd20));
    send(4'd4, 64'h0000_0000_0000_0F0F, 64'd2, 5'd21, model(4'd4, 64'h0000_0000_0000_0F0F, 64'd2, 5'd21));
    rx0 = rx_cnt;
    in_valid = 1'b1;
    in_op = 4'd5;
    in_src1 = 64'h1;
    in_src2 = 64'd0;
    in_tag = 5'd22;
    flush = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid: got out_valid=%0b, required 0", out_valid);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rx_cnt != rx0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: got %0d results after flush, required 0", rx_cnt - rx0);
    end
    @(posedge clk);
    #1;
    send(4'd6, 64'h1, 64'd1, 5'd23, {1'b0, 5'd23, 64'h8000_0000_0000_0000});
    drain();
    checks++;
    if (rx_cnt != rx0 + 1) begin
      errors++;
      $display("FAIL flush_recover: got %0d results, required 1", rx_cnt - rx0);
    end
  endtask

  task automatic test_reset_mid();
    int rx0;
    out_ready = 1'b1;
    send(4'd3, 64'hF0, 64'd4, 5'd24, {1'b0, 5'd24, 64'hF});
    send(4'd4, 64'hF0, 64'd4, 5'd25, {1'b0, 5'd25, 64'hF00});
    send(4'd5, 64'hF0, 64'd4, 5'd26, {1'b0, 5'd26, 64'hF});
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_before: got out_valid=%0b, required 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: got out_valid=%0b, required 0", out_valid);
    end
    #1;
    rst_n = 1'b1;
    rx0 = rx_cnt;
    repeat (5) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || rx_cnt != rx0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got out_valid=%0b results=%0d, required 0/0", out_valid, rx_cnt - rx0);
    end
    @(posedge clk);
    #1;
    send(4'd9, 64'h8000_0000, 64'd1, 5'd27, {1'b0, 5'd27, 64'h1});
    drain();
  endtask

  task automatic test_xlen32();
    logic [37:0] obs;
    run32(4'd0, 32'h8000_0000, 32'd4, 5'd3, obs);
    checks++;
    if (obs !== {1'b1, 5'd3, 32'd0}) begin
      errors++;
      $display("FAIL xlen32_sraw: got %h, required %h", obs, {1'b1, 5'd3, 32'd0});
    end
    run32(4'd5, 32'h8000_0000, 32'd4, 5'd4, obs);
    checks++;
    if (obs !== {1'b0, 5'd4, 32'hF800_0000}) begin
      errors++;
      $display("FAIL xlen32_sra: got %h, required %h", obs, {1'b0, 5'd4, 32'hF800_0000});
    end
    run32(4'd7, 32'h8000_0001, 32'h21, 5'd5, obs);
    checks++;
    if (obs !== {1'b0, 5'd5, 32'h0000_0003}) begin
      errors++;
      $display("FAIL xlen32_rol: got %h, required %h", obs, {1'b0, 5'd5, 32'h0000_0003});
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    acc_cnt = 0;
    rx_cnt = 0;
    done = 1'b0;
    test_reset();
    test_sra_latency();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_xlen32();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d results outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
